// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 window fetcher: image geometry defaults,
// tap offsets, tap-slot index type and FSM state encoding.
package conv_pkg;

   localparam int DEF_IMG_W = 256;
   localparam int DEF_IMG_H = 128;
   localparam int DEF_AW    = 15;

   localparam int NTAPS = 9;

   // Tap index 0..8 addresses a window slot; value NTAPS marks the drain cycle.
   typedef logic [3:0] tap_idx_t;

   localparam tap_idx_t TAP_FIRST = tap_idx_t'(0);
   localparam tap_idx_t TAP_DRAIN = tap_idx_t'(NTAPS);

   typedef enum logic [1:0] {
      OFF_NEG,
      OFF_ZERO,
      OFF_POS
   } tap_off_e;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } fetch_state_e;

   // Tap k = 3*(dy+1) + (dx+1): the column offset cycles fastest.
   function automatic tap_off_e tap_dx(input tap_idx_t k);
      tap_off_e off;
      case (k)
         4'd0, 4'd3, 4'd6: off = OFF_NEG;
         4'd1, 4'd4, 4'd7: off = OFF_ZERO;
         default:          off = OFF_POS;
      endcase
      return off;
   endfunction

   function automatic tap_off_e tap_dy(input tap_idx_t k);
      tap_off_e off;
      case (k)
         4'd0, 4'd1, 4'd2: off = OFF_NEG;
         4'd3, 4'd4, 4'd5: off = OFF_ZERO;
         default:          off = OFF_POS;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/window_tap_gen.sv
// Combinational tap decoder: centre (x,y) plus tap index -> in-bounds flag and
// SRAM address {y', x'} (power-of-two width makes the row stride a concatenation).
module window_tap_gen
   import conv_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int AW    = DEF_AW
)
(
   input  logic [$clog2(IMG_W)-1:0] cx,
   input  logic [$clog2(IMG_H)-1:0] cy,
   input  tap_idx_t                 tap,
   output logic                     inb,
   output logic [AW-1:0]            addr
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   logic [XW-1:0] nx;
   logic [YW-1:0] ny;
   logic          x_ok;
   logic          y_ok;

   always_comb begin
      nx   = cx;
      x_ok = 1'b1;
      case (tap_dx(tap))
         OFF_NEG: begin
            nx   = cx - XW'(1);
            x_ok = (cx != '0);
         end
         OFF_POS: begin
            nx   = cx + XW'(1);
            x_ok = (cx != X_LAST);
         end
         default: ;
      endcase
   end

   always_comb begin
      ny   = cy;
      y_ok = 1'b1;
      case (tap_dy(tap))
         OFF_NEG: begin
            ny   = cy - YW'(1);
            y_ok = (cy != '0);
         end
         OFF_POS: begin
            ny   = cy + YW'(1);
            y_ok = (cy != Y_LAST);
         end
         default: ;
      endcase
   end

   // The drain index never produces a read.
   assign inb  = x_ok && y_ok && (tap < TAP_DRAIN);
   assign addr = AW'({ny, nx});

endmodule

// File: rtl/conv_window_fetch.sv
// Streams zero-padded 3x3 windows of the image SRAM in raster order, one tap read
// per cycle, with the window held stable on a valid/ready interface.
module conv_window_fetch
   import conv_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int AW    = DEF_AW
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     sram_en,
   output logic                     sram_wen,
   output logic [AW-1:0]            sram_addr,
   input  logic [7:0]               sram_q,
   output logic                     win_valid,
   input  logic                     win_ready,
   output logic [8*NTAPS-1:0]       win_data,
   output logic [$clog2(IMG_W)-1:0] win_x,
   output logic [$clog2(IMG_H)-1:0] win_y
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   fetch_state_e  state_reg, state_next;
   tap_idx_t      tap_reg, tap_next;
   logic [XW-1:0] cx_reg, cx_next;
   logic [YW-1:0] cy_reg, cy_next;
   logic          done_reg, done_next;

   // Tag travelling alongside the one-cycle SRAM read.
   logic          rd_pend_reg;
   logic          rd_inb_reg;
   tap_idx_t      rd_slot_reg;

   logic          tap_inb;
   logic [AW-1:0] tap_addr;
   logic          tap_slot;
   logic          issue;

   window_tap_gen #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .AW    (AW)
   ) u_tap_gen (
      .cx   (cx_reg),
      .cy   (cy_reg),
      .tap  (tap_reg),
      .inb  (tap_inb),
      .addr (tap_addr)
   );

   assign tap_slot = (state_reg == FETCH) && (tap_reg != TAP_DRAIN);
   assign issue    = (state_reg == FETCH) && tap_inb;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         tap_reg   <= TAP_FIRST;
         cx_reg    <= '0;
         cy_reg    <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         tap_reg   <= tap_next;
         cx_reg    <= cx_next;
         cy_reg    <= cy_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      tap_next   = tap_reg;
      cx_next    = cx_reg;
      cy_next    = cy_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = FETCH;
               tap_next   = TAP_FIRST;
               cx_next    = '0;
               cy_next    = '0;
            end
         end
         FETCH: begin
            // The drain cycle lets the tap-8 read land before the window is shown.
            if (tap_reg == TAP_DRAIN) begin
               state_next = HOLD;
            end else begin
               tap_next = tap_reg + tap_idx_t'(1);
            end
         end
         HOLD: begin
            if (win_ready) begin
               tap_next = TAP_FIRST;
               if (cx_reg == X_LAST) begin
                  cx_next = '0;
                  if (cy_reg == Y_LAST) begin
                     cy_next    = '0;
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end else begin
                     cy_next    = cy_reg + YW'(1);
                     state_next = FETCH;
                  end
               end else begin
                  cx_next    = cx_reg + XW'(1);
                  state_next = FETCH;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_pend_reg <= 1'b0;
         rd_inb_reg  <= 1'b0;
         rd_slot_reg <= TAP_FIRST;
      end else begin
         rd_pend_reg <= tap_slot;
         rd_inb_reg  <= tap_inb;
         rd_slot_reg <= tap_reg;
      end
   end

   // Out-of-bounds taps still occupy their slot, loading the zero pad.
   generate
      for (genvar gi = 0; gi < NTAPS; gi++) begin : g_slot
         logic [7:0] slot_reg;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               slot_reg <= 8'h00;
            end else if (rd_pend_reg && (rd_slot_reg == tap_idx_t'(gi))) begin
               slot_reg <= rd_inb_reg ? sram_q : 8'h00;
            end
         end

         assign win_data[8*gi +: 8] = slot_reg;
      end
   endgenerate

   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;
   assign win_valid = (state_reg == HOLD);
   assign win_x     = cx_reg;
   assign win_y     = cy_reg;
   assign sram_en   = issue;
   assign sram_wen  = 1'b1;
   assign sram_addr = issue ? tap_addr : '0;

endmodule

// File: doc/conv_window_fetch.md
# conv_window_fetch

Reads the 8-bit gray-scale image from the 32768x8 image SRAM and delivers one zero-padded 3x3 neighbourhood per output pixel, in raster order, to the downstream convolution datapath. It is the SRAM's only reader during a convolution pass. It hides the SRAM's one-cycle read latency and accepts back-pressure through a valid/ready handshake.

## Interface
- IMG_W, 256, image width in pixels; power of two.
- IMG_H, 128, image height in pixels; power of two; IMG_W*IMG_H ≤ 2^AW.
- AW, 15, SRAM address width.
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a frame pass when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last window handshake.
- sram_en  out  1  SRAM enable; high only for in-bounds tap reads.
- sram_wen  out  1  tied 1 (read only).
- sram_addr  out  AW  read address = y*IMG_W + x.
- sram_q  in  8  SRAM read data; valid the cycle after the address.
- win_valid  out  1  window available.
- win_ready  in  1  consumer accepts window.
- win_data  out  72  tap k in bits [8k+7:8k], k = 3*(dy+1)+(dx+1), dx,dy ∈ {-1,0,1}.
- win_x  out  log2(IMG_W)  centre column.
- win_y  out  log2(IMG_H)  centre row.

## Operation
- FSM states: IDLE, FETCH, HOLD.
- IDLE: when start=1, centre = (0,0) and go to FETCH.
- start while busy is ignored.
- FETCH: issue tap k = 0..8, one per cycle.
  - In-bounds tap: sram_en=1, sram_addr = tap address.
  - Out-of-bounds tap (x±1 or y±1 outside the image): sram_en=0, sram_addr=0. A per-tap valid/slot tag travels with the read, and slot k loads 0x00.
  - Returned data is written into slot k one cycle after issue.
  - After slot 8 is loaded, go to HOLD.
- HOLD:
  - win_valid=1; win_data, win_x and win_y are held stable while win_ready=0.
  - No sram_en while in HOLD.
  - On a handshake, advance the centre in raster order (x wraps to 0, then y+1) and go to FETCH.
  - On a handshake at (IMG_W-1, IMG_H-1), go to IDLE and pulse done.
- Reset values: all outputs 0 except sram_wen=1; state IDLE; centre (0,0).
- Reset asserted mid-pass: IDLE and reset values from the next cycle. The in-flight read is discarded. The next start restarts at (0,0).

## Timing
- Let F be the first FETCH cycle of a window.
  - Tap k is on sram_addr in cycle F+k.
  - Slot k is registered at the end of cycle F+k+1.
  - win_valid rises in cycle F+10.
- With win_ready held at 1: handshake in F+10, next FETCH at F+11, so 11 cycles per window.
- A full 256x128 frame takes 32768 windows, 360448 cycles from the first FETCH to the last handshake.
- start accepted in cycle S: busy=1 and the first FETCH in S+1.
- done=1 and busy=0 in the cycle after the final handshake.

## Structure
- Package conv_pkg holds:
  - IMG_W, IMG_H, AW defaults;
  - NTAPS=9;
  - tap dx/dy offset constants;
  - the FSM state enum;
  - a tap-slot index type.
- Sub-module window_tap_gen (combinational) maps centre (x,y) and tap k to an in-bounds flag and an SRAM address. The address is {y', x'} because IMG_W is a power of two.

## Test plan
- Reset, then idle 5 cycles: all outputs 0, sram_wen=1, no sram_en, busy=0.
- Memory ram[a] = a[7:0] ^ a[14:8]; start; first window (0,0):
  - sram_en only in F+4, F+5, F+7, F+8, at addresses 0, 1, 256, 257;
  - slots 0,1,2,3,6 = 0x00;
  - slots 4,5,7,8 = 0x00, 0x01, 0x01, 0x00;
  - win_valid in F+10.
- Back-pressure: win_ready=0 for 20 cycles during HOLD: win_data, win_x, win_y unchanged, sram_en=0 throughout; ready=1 produces exactly one handshake, then FETCH for (1,0).
- Last window (255,127):
  - reads only 32510, 32511, 32766, 32767 (taps 0,1,3,4);
  - taps 2,5,6,7,8 = 0;
  - done pulses for one cycle after the handshake and busy falls.
- rst_n=0 for one cycle right after tap 4 of window (5,3) is issued:
  - next cycle IDLE, no sram_en, win_valid=0;
  - a later start fetches (0,0) first.
- win_ready tied 1, start pulsed again mid-frame (ignored):
  - exactly 32768 windows in raster order;
  - last handshake 360448 cycles after the first FETCH;
  - done pulses once.
